// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: instruction/address bus types, zero and NOP words,
// and the fixed PC increment.
package inst_fetch_pkg;
  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam InstBus      ZeroWord = 32'h0000_0000;
  localparam InstBus      NopInst  = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst}. The head is read straight from
// storage flops; flush empties it in one cycle.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, in-order ROM requests under a queue-credit rule, prefetch
// queue feeding decode. Define FETCH_BYPASS_EN to forward a response to decode when the queue is empty.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ready_i,
  input  logic              rom_valid_i,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  // drop can exceed DEPTH when flushes follow each other closely, so it gets headroom
  localparam int DW = CW + 3;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     count;
  logic [DW-1:0]     drop;
  logic [DW-1:0]     drop_sum;
  logic [DW-1:0]     drop_flush;
  logic              has_credit;
  logic              accept;
  logic              resp_take;
  logic              bypass;
  logic              push;
  logic              pop;

  assign rom_addr_o = pc;

  always_comb begin
    has_credit = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    rom_ce_o   = !rst && !flush_i && has_credit;
    accept     = rom_ce_o && rom_ready_i;
    resp_take  = rom_valid_i && !flush_i && (drop == '0);
`ifdef FETCH_BYPASS_EN
    bypass     = !rst && resp_take && (count == '0) && !stall_i;
`else
    bypass     = 1'b0;
`endif
    push       = resp_take && !bypass;
    pop        = (count != '0) && !stall_i && !flush_i;
    // a response landing in the flush cycle retires one of the requests still in flight
    drop_sum   = drop + DW'(outstanding);
    if (rom_valid_i && (drop_sum != '0)) drop_flush = drop_sum - DW'(1);
    else                                 drop_flush = drop_sum;
    if (bypass) begin
      id_valid_o = 1'b1;
      id_pc_o    = resp_pc;
      id_inst_o  = rom_data_i;
    end else if (count != '0) begin
      id_valid_o = 1'b1;
      id_pc_o    = head_pc;
      id_inst_o  = head_inst;
    end else begin
      id_valid_o = 1'b0;
      id_pc_o    = ADDR_W'(ZeroWord);
      id_inst_o  = INST_W'(NopInst);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (flush_i) begin
      pc          <= flush_pc_i;
      resp_pc     <= flush_pc_i;
      outstanding <= '0;
      drop        <= drop_flush;
    end else begin
      if (accept)    pc      <= pc + ADDR_W'(PC_STEP);
      if (resp_take) resp_pc <= resp_pc + ADDR_W'(PC_STEP);
      if (rom_valid_i && (drop != '0)) drop <= drop - DW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(resp_take);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush_i),
    .din   ({resp_pc, rom_data_i}),
    .dout  ({head_pc, head_inst}),
    .count (count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a variable-latency ROM model, directed phases that
// queue expected {pc, inst} pairs, and a monitor that checks every word decode consumes.
module tb_inst_fetch;
  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        rom_ready;
  logic        rom_valid;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat = 1;
  int rdy_rand = 0;
  int n_acc = 0;
  int mon_first = -1;
  int mon_last = -1;
  int c0;
  int a0;
  logic [63:0] sb [$];
  logic [63:0] pend [$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_a = 32'h0;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_o    (rom_ce),
    .rom_addr_o  (rom_addr),
    .rom_ready_i (rom_ready),
    .rom_valid_i (rom_valid),
    .rom_data_i  (rom_data),
    .stall_i     (stall),
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .id_valid_o  (id_valid),
    .id_pc_o     (id_pc),
    .id_inst_o   (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      sb.push_back({a, word(a)});
    end
  endtask

  task automatic drain(input int budget, input string nm);
    int k;
    k = 0;
    stall = 1'b0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    stall = 1'b1;
    check(nm, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_pc = tgt;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ROM model: in-order responses `lat` cycles after acceptance, optional random ready
  always begin
    @(negedge clk);
    if (rst) begin
      pend.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && rom_ce) check("addr_hold", 64'(rom_addr), 64'(hold_a));
      hold_v = rom_ce && !rom_ready;
      hold_a = rom_addr;
      if (rom_ce && rom_ready) begin
        pend.push_back({rom_addr, 32'(cyc + lat)});
        n_acc++;
      end
    end
    @(posedge clk); #1;
    rom_ready = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && pend.size() != 0 && int'(pend[0][31:0]) <= cyc) begin
      rom_valid = 1'b1;
      rom_data  = word(pend[0][63:32]);
      void'(pend.pop_front());
    end else begin
      rom_valid = 1'b0;
      rom_data  = 32'h0;
    end
  end

  // Monitor: every word decode consumes must be the next expected one
  always @(negedge clk) begin
    if (!rst && id_valid && !stall) begin
      if (sb.size() == 0) begin
        check("spurious_id_pc", 64'(id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("id_pc", 64'(id_pc), 64'(e[63:32]));
        check("id_inst", 64'(id_inst), 64'(e[31:0]));
        if (mon_first < 0) mon_first = cyc;
        mon_last = cyc;
      end
    end
    if (!rst && !id_valid) check("nop_when_invalid", 64'(id_inst), 64'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d passed %0d", n_chk, n_pass);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    rom_ready = 1'b1; rom_valid = 1'b0; rom_data = 32'h0;
    #1 rst = 1'b1;
    #2;
    check("rst_rom_ce", 64'(rom_ce), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_inst", 64'(id_inst), 64'd0);
    repeat (2) @(posedge clk); #1;

    // 1-cycle ROM, always ready, no stall
    push_exp(32'h0, 8);
    mon_first = -1;
    rst = 1'b0; stall = 1'b0; c0 = cyc;
    @(negedge clk);
    check("a_first_ce", 64'(rom_ce), 64'd1);
    check("a_first_addr", 64'(rom_addr), 64'd0);
    check("a_valid_c0", 64'(id_valid), 64'd0);
    @(negedge clk);
    check("a_valid_c1", 64'(id_valid), 64'd0);
    @(negedge clk);
    check("a_valid_c2", 64'(id_valid), 64'd1);
    @(posedge clk); #1;
    drain(40, "a_drain");
    check("a_latency", 64'(mon_first - c0), 64'd2);
    check("a_throughput", 64'(mon_last - mon_first), 64'd7);

    // stall held for 10 cycles after a flush (flush wins over stall)
    do_flush(32'h200);
    a0 = n_acc;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    check("b_held_mid_pc", 64'(id_pc), 64'h200);
    repeat (7) @(posedge clk); #1;
    check("b_stall_accepts", 64'(n_acc - a0), 64'd4);
    @(negedge clk);
    check("b_ce_dropped", 64'(rom_ce), 64'd0);
    check("b_held_valid", 64'(id_valid), 64'd1);
    check("b_held_pc", 64'(id_pc), 64'h200);
    check("b_held_inst", 64'(id_inst), 64'(32'h5A5A_0200));
    @(posedge clk); #1;
    push_exp(32'h200, 10);
    drain(80, "b_drain");

    // 3-cycle ROM, flush with two requests in flight
    lat = 3;
    do_flush(32'h300);
    a0 = n_acc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("c_inflight", 64'(n_acc - a0), 64'd2);
    do_flush(32'h100);
    push_exp(32'h100, 6);
    drain(80, "c_drain");

    // flush in the same cycle as a response
    lat = 1;
    do_flush(32'h480);
    repeat (10) @(posedge clk); #1;
    do_flush(32'h400);
    @(posedge clk); #1;
    do_flush(32'h500);
    push_exp(32'h500, 6);
    drain(80, "d_drain");

    // randomly toggling ROM ready
    lat = 2; rdy_rand = 1;
    do_flush(32'h600);
    push_exp(32'h600, 12);
    drain(300, "e_drain");
    rdy_rand = 0;

    // reset with a full queue
    lat = 1;
    do_flush(32'h700);
    repeat (10) @(posedge clk); #1;
    @(negedge clk);
    check("f_full_valid", 64'(id_valid), 64'd1);
    check("f_full_pc", 64'(id_pc), 64'h700);
    check("f_full_ce", 64'(rom_ce), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("f_rst_rom_ce", 64'(rom_ce), 64'd0);
    check("f_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("f_rst_id_valid", 64'(id_valid), 64'd0);
    check("f_rst_id_pc", 64'(id_pc), 64'd0);
    check("f_rst_id_inst", 64'(id_inst), 64'd0);
    repeat (2) @(posedge clk); #1;
    push_exp(32'h0, 6);
    rst = 1'b0;
    @(negedge clk);
    check("f_restart_ce", 64'(rom_ce), 64'd1);
    check("f_restart_addr", 64'(rom_addr), 64'd0);
    @(posedge clk); #1;
    drain(60, "f_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Parametrised fetch stage combining the PC register and IF/ID register. It issues in-order instruction requests to a ROM with variable latency, buffers the returned words with their PCs in a small prefetch queue, and presents them to the decode stage. It adds stall back-pressure and branch/flush redirection. It sits between the instruction ROM and the `id` stage inside the core top level.

## Interface
Parameters:
- `ADDR_W`, 32: PC / ROM address width.
- `INST_W`, 32: instruction width.
- `DEPTH`, 4: prefetch queue entries; power of 2, ≥ 2.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rom_ce_o`  out  1  request valid.
- `rom_addr_o`  out  ADDR_W  request address (= PC).
- `rom_ready_i`  in  1  ROM accepts the request this cycle.
- `rom_valid_i`  in  1  response valid; responses return in request order.
- `rom_data_i`  in  INST_W  response word.
- `stall_i`  in  1  decode cannot consume this cycle.
- `flush_i`  in  1  redirect fetch.
- `flush_pc_i`  in  ADDR_W  redirect target.
- `id_valid_o`  out  1  `id_pc_o`/`id_inst_o` hold a valid instruction.
- `id_pc_o`  out  ADDR_W  PC of the presented instruction.
- `id_inst_o`  out  INST_W  presented instruction; 0 (NOP) when not valid.

## Operation
- Counters:
  - `pc` is the next address to issue.
  - `resp_pc` is the PC of the next expected response.
  - `outstanding` counts accepted requests not yet returned.
  - `drop` counts stale responses to discard.
  - `count` is queue occupancy.
- Issue: `rom_ce_o = !rst && !flush_i && (count + outstanding < DEPTH)`.
  - Accept means `rom_ce_o && rom_ready_i`.
  - On accept, `pc += 4` and `outstanding++`.
  - The credit rule guarantees the queue never overflows.
- Response, when `rom_valid_i`:
  - If `drop > 0`: the response is discarded and `drop--`.
  - Otherwise: push {`resp_pc`, `rom_data_i`}, then `resp_pc += 4`, `outstanding--`.
- Pop: when `id_valid_o && !stall_i`. Push and pop in the same cycle are legal at any occupancy.
- Flush (highest priority):
  - `pc` and `resp_pc` are set to `flush_pc_i`; the queue is emptied.
  - `drop` is set to the outstanding requests not yet returned: `outstanding` plus `drop`, excluding any response arriving in the flush cycle. A response arriving in the flush cycle is discarded.
  - `outstanding` is set to 0; no request is issued in the flush cycle.
- Flush with stall in the same cycle: flush wins.
- Addresses wrap modulo 2^ADDR_W; pointers wrap modulo DEPTH.
- Reset, including mid-operation:
  - Clears all counters and the queue. `pc` and `resp_pc` are set to `RESET_PC`.
  - In-flight requests are forgotten; the ROM shares `rst`.
- Reset values: `rom_ce_o` = 0, `rom_addr_o` = `RESET_PC`, `id_valid_o` = 0, `id_pc_o` = 0, `id_inst_o` = 0.

## Timing
- `id_*` are driven from queue storage flops (queue head), not from ROM inputs (except under the bypass option).
- With a 1-cycle ROM (accept in cycle n, valid in n+1), the instruction is on `id_*` in cycle n+2.
- With no stall, throughput is 1 instruction/cycle once the ROM latency is ≤ DEPTH−1 cycles.
- After a flush in cycle f, the first request is `flush_pc_i`, issued in cycle f+1. `id_valid_o` = 0 in cycle f+1.
- After `rst` deasserts, the first request (`RESET_PC`) is issued in the first cycle.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - Applies when the queue is empty, `drop == 0`, `rom_valid_i` = 1, `stall_i` = 0 and `flush_i` = 0.
  - In that case the response goes combinationally to `id_*` in the same cycle and is not pushed.
  - 1-cycle ROM latency to decode becomes 1.
- Not defined: every response passes through the queue; `id_*` are purely registered.

## Structure
- Existing shared defines file gains `InstAddrBus`, `InstBus`, `ZeroWord` and `NopInst`.
- One sub-module, `fetch_fifo`: a synchronous FIFO of {pc, inst} with parameters `DEPTH` and `ADDR_W+INST_W`, providing push/pop/flush/count.

## Test plan
- Reset, 1-cycle always-ready ROM, no stall → requests 0x0, 0x4, 0x8…; `id_valid_o` from cycle 2, one instruction per cycle, PCs in order.
- Hold `stall_i` = 1 for 10 cycles, DEPTH = 4 → at most 4 requests issued; `rom_ce_o` then drops; same `id_*` held; resumes without loss.
- 3-cycle ROM latency, flush to 0x100 with 2 outstanding → both stale responses discarded; next presented instruction has `id_pc_o` = 0x100.
- Flush and `rom_valid_i` in the same cycle → that word never appears on `id_*`.
- `rom_ready_i` toggling randomly → `rom_addr_o` is held until accepted; no duplicate or skipped PC.
- Assert `rst` mid-stream with a full queue → all outputs go to reset values immediately; after release, fetch restarts at `RESET_PC`.
